// File: rtl/tpu_host_ctrl_if.sv
// Single-beat host bus between a host master and the TPU host controller.
`default_nettype none

interface tpu_host_ctrl_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] dataIn;
  logic [DATAW-1:0] dataOut;
  logic             ack;
  logic             err;
  logic             done_irq;

  modport master (
    output req, r_w, addr, dataIn,
    input  dataOut, ack, err, done_irq
  );

  modport slave (
    input  req, r_w, addr, dataIn,
    output dataOut, ack, err, done_irq
  );
endinterface

`default_nettype wire

// File: rtl/tpu_host_ctrl.sv
// TPU host controller: decodes host requests into A/B row writes, C readback and a CSR,
// and sequences the optional C clear plus the systolic compute window.
`default_nettype none

module tpu_host_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  tpu_host_ctrl_if.slave             host,
  output logic                       mem_a_wr,
  output logic                       mem_b_wr,
  output logic [$clog2(DIM)-1:0]     mem_row,
  output logic [DIM*BITS_AB-1:0]     mem_din,
  output logic                       arr_en,
  output logic                       arr_c_wr,
  output logic [$clog2(DIM)-1:0]     arr_c_row,
  output logic [DIM*BITS_C-1:0]      arr_c_din,
  input  wire logic [DIM*BITS_C-1:0] arr_c_dout
);
  localparam int ROWW   = $clog2(DIM);
  localparam int CWORDS = DIM*BITS_C/DATAW;
  localparam int CWW    = (CWORDS > 1) ? $clog2(CWORDS) : 1;
  localparam int NCOMP  = 3*DIM-2;
  localparam int CNTW   = $clog2(NCOMP+1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CREAD   = 2'd1;
  localparam logic [1:0] S_CLEAR   = 2'd2;
  localparam logic [1:0] S_COMPUTE = 2'd3;

  localparam logic [3:0] R_CSR = 4'd0;
  localparam logic [3:0] R_A   = 4'd1;
  localparam logic [3:0] R_B   = 4'd2;
  localparam logic [3:0] R_C   = 4'd3;

  logic [1:0]       r_state, w_next;
  logic [CNTW-1:0]  r_cnt;
  logic             r_go, r_done, r_irq, r_ack, r_err;
  logic [DATAW-1:0] r_dout;
  logic             r_mem_a_wr, r_mem_b_wr;
  logic [ROWW-1:0]  r_mem_row, r_crow;
  logic [DATAW-1:0] r_mem_din;
  logic [CWW-1:0]   r_cword;

  logic [3:0]       w_region;
  logic             w_busy, w_done_set, w_csr_rd;
  logic [DATAW-1:0] w_csr_rdata;
  logic [DATAW-1:0] w_cword [2**CWW];
  wire              w_unused = &{1'b0, host.addr};

  assign w_region    = host.addr[ADDRW-1 -: 4];
  assign w_busy      = (r_state == S_CLEAR) || (r_state == S_COMPUTE);
  assign w_done_set  = (r_state == S_COMPUTE) && (r_cnt == CNTW'(NCOMP-1));
  assign w_csr_rd    = host.req && !host.r_w && (w_region == R_CSR);
  // A read coinciding with completion must already report done.
  assign w_csr_rdata = {{(DATAW-2){1'b0}}, r_done | w_done_set, w_busy};

  for (genvar i = 0; i < 2**CWW; i++) begin : g_cw
    if (i < CWORDS) begin : g_word
      assign w_cword[i] = arr_c_dout[i*DATAW +: DATAW];
    end else begin : g_pad
      assign w_cword[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (host.req && host.r_w && (w_region == R_CSR)) begin
          if (host.dataIn[1])      w_next = S_CLEAR;
          else if (host.dataIn[0]) w_next = S_COMPUTE;
        end else if (host.req && !host.r_w && (w_region == R_C)) begin
          w_next = S_CREAD;
        end
      end
      S_CREAD:   w_next = S_IDLE;
      S_CLEAR:   if (r_cnt == CNTW'(DIM-1)) w_next = r_go ? S_COMPUTE : S_IDLE;
      S_COMPUTE: if (w_done_set) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    arr_en    = 1'b0;
    arr_c_wr  = 1'b0;
    arr_c_row = '0;
    case (r_state)
      S_CREAD:   arr_c_row = r_crow;
      S_CLEAR: begin
        arr_c_wr  = 1'b1;
        arr_c_row = r_cnt[ROWW-1:0];
      end
      S_COMPUTE: arr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_go       <= 1'b0;
      r_done     <= 1'b0;
      r_irq      <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
      r_mem_a_wr <= 1'b0;
      r_mem_b_wr <= 1'b0;
      r_mem_row  <= '0;
      r_mem_din  <= '0;
      r_crow     <= '0;
      r_cword    <= '0;
    end else begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
      r_mem_a_wr <= 1'b0;
      r_mem_b_wr <= 1'b0;
      r_irq      <= 1'b0;
      r_cnt      <= (r_state != w_next) ? '0 : r_cnt + 1'b1;
      if (w_done_set) begin
        r_done <= 1'b1;
        r_irq  <= 1'b1;
      end
      if (r_state == S_CREAD) begin
        r_ack  <= 1'b1;
        r_dout <= w_cword[r_cword];
      end
      if (host.req) begin
        r_ack <= 1'b1;
        if (w_busy) begin
          if (w_csr_rd) begin
            r_dout <= w_csr_rdata;
            r_done <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          case (w_region)
            R_CSR: begin
              if (host.r_w) begin
                r_go <= host.dataIn[0];
                if (host.dataIn[0]) r_done <= 1'b0;
              end else begin
                r_dout <= w_csr_rdata;
                r_done <= 1'b0;
              end
            end
            R_A, R_B: begin
              if (host.r_w) begin
                r_mem_a_wr <= (w_region == R_A);
                r_mem_b_wr <= (w_region == R_B);
                r_mem_row  <= host.addr[ROWW-1:0];
                r_mem_din  <= host.dataIn;
              end else begin
                r_err <= 1'b1;
              end
            end
            R_C: begin
              if (!host.r_w) begin
                r_ack   <= 1'b0;
                r_cword <= host.addr[CWW-1:0];
                r_crow  <= host.addr[CWW+ROWW-1:CWW];
              end else begin
                r_err <= 1'b1;
              end
            end
            default: r_err <= 1'b1;
          endcase
        end
      end
    end
  end

  assign host.ack      = r_ack;
  assign host.err      = r_err;
  assign host.dataOut  = r_dout;
  assign host.done_irq = r_irq;
  assign mem_a_wr      = r_mem_a_wr;
  assign mem_b_wr      = r_mem_b_wr;
  assign mem_row       = r_mem_row;
  assign mem_din       = r_mem_din;
  assign arr_c_din     = '0;
endmodule

`default_nettype wire
